// File: rtl/bus_mem_arb_pkg.sv
// Shared definitions for the multi-master bus memory: latency limit,
// clear sequencer state encoding and a one-hot to index helper.
package bus_mem_arb_pkg;

  localparam int RD_LAT_MAX = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

  // Handles up to 8 masters; callers size-cast their one-hot vector to 8 bits.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one grant per cycle, search starts one past the last
// granted master, pointer moves only when something is granted.
module rr_arbiter
  import bus_mem_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 enable,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_reg;
  logic [N-1:0]  mask;
  logic [N-1:0]  masked;
  logic [N-1:0]  pick_src;

  // Prefer requesters at or above the pointer; wrap to the lowest otherwise.
  always_comb begin
    mask     = ~((N'(1) << ptr_reg) - N'(1));
    masked   = req & mask;
    pick_src = (|masked) ? masked : req;
    gnt      = enable ? (pick_src & (~pick_src + N'(1))) : '0;
    gnt_idx  = IW'(onehot_to_idx(8'(gnt)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else if (|gnt) begin
      ptr_reg <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/bus_mem_arb.sv
// Shared DEPTH x DW memory for N_MST bus masters: round-robin access,
// pipelined tagged reads and a hardware clear sequencer.
module bus_mem_arb
  import bus_mem_arb_pkg::*;
#(
  parameter int DW     = 10,
  parameter int AW     = 8,
  parameter int N_MST  = 2,
  parameter int RD_LAT = 1,
  parameter int IDW    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_MST-1:0]    req,
  input  logic [N_MST-1:0]    we,
  input  logic [N_MST*AW-1:0] addr,
  input  logic [N_MST*DW-1:0] wdata,
  output logic [N_MST-1:0]    gnt,
  output logic [DW-1:0]       rd_data,
  output logic                rd_valid,
  output logic [IDW-1:0]      rd_id,
  input  logic                clr_start,
  output logic                clr_busy
);

  localparam int DEPTH = 2 ** AW;
  localparam int IW    = $clog2(N_MST);
  localparam logic [AW:0] CNT_LAST = {1'b0, {AW{1'b1}}};

  clr_state_t     state_reg;
  logic [AW:0]    cnt_reg;
  logic           clr_active;
  logic           arb_en;
  logic [IW-1:0]  gnt_idx;
  logic           granted;
  logic           sel_we;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_wdata;
  logic           wr_fire;
  logic           rd_fire;
  logic           mem_we;
  logic [AW-1:0]  mem_waddr;
  logic [DW-1:0]  mem_wdata;

  logic [DW-1:0]  mem [DEPTH];
  logic [DW-1:0]  rd_q;
  logic           v1_reg;
  logic [IDW-1:0] id1_reg;
  logic           out_v;
  logic [IDW-1:0] out_id;
  logic [DW-1:0]  out_d;

  assign clr_active = (state_reg == CLEAR);
  // Gating with rst_n keeps gnt low for the whole reset, not just after an edge.
  assign arb_en     = rst_n && !clr_active;

  rr_arbiter #(.N(N_MST)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .enable  (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign granted   = |gnt;
  assign sel_we    = we[gnt_idx];
  assign sel_addr  = addr[int'(gnt_idx)*AW +: AW];
  assign sel_wdata = wdata[int'(gnt_idx)*DW +: DW];
  assign wr_fire   = granted && sel_we;
  assign rd_fire   = granted && !sel_we;

  // Grants are blocked during a clear, so the single write port is never contended.
  assign mem_we    = wr_fire || clr_active;
  assign mem_waddr = clr_active ? cnt_reg[AW-1:0] : sel_addr;
  assign mem_wdata = clr_active ? '0 : sel_wdata;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (rd_fire) rd_q <= mem[sel_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (clr_start) begin
            state_reg <= CLEAR;
            cnt_reg   <= '0;
          end
        end
        CLEAR: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign clr_busy = clr_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg  <= 1'b0;
      id1_reg <= '0;
    end else begin
      v1_reg <= rd_fire;
      if (rd_fire) id1_reg <= IDW'(gnt_idx);
    end
  end

  generate
    if (RD_LAT >= RD_LAT_MAX) begin : g_lat2
      logic           v2_reg;
      logic [IDW-1:0] id2_reg;
      logic [DW-1:0]  d2_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v2_reg  <= 1'b0;
          id2_reg <= '0;
          d2_reg  <= '0;
        end else begin
          v2_reg  <= v1_reg;
          id2_reg <= id1_reg;
          d2_reg  <= rd_q;
        end
      end

      assign out_v  = v2_reg;
      assign out_id = id2_reg;
      assign out_d  = d2_reg;
    end else begin : g_lat1
      assign out_v  = v1_reg;
      assign out_id = id1_reg;
      assign out_d  = rd_q;
    end
  endgenerate

  assign rd_valid = out_v;
  assign rd_id    = out_id;
  assign rd_data  = out_v ? out_d : '0;

endmodule

// File: tb/tb_bus_mem_arb.sv
// Randomised + directed bench for bus_mem_arb; runs an RD_LAT=1 and an RD_LAT=2
// instance side by side against one behavioural model of the memory.
module tb_bus_mem_arb;

  localparam int DW    = 10;
  localparam int AW    = 8;
  localparam int N     = 2;
  localparam int IDW   = 3;
  localparam int DEPTH = 256;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    we = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic            clr_start = 1'b0;

  logic [N-1:0]    gnt_a, gnt_b;
  logic [DW-1:0]   rd_data_a, rd_data_b;
  logic            rd_valid_a, rd_valid_b;
  logic [IDW-1:0]  rd_id_a, rd_id_b;
  logic            clr_busy_a, clr_busy_b;

  always #5 clk = ~clk;

  bus_mem_arb #(.DW(DW), .AW(AW), .N_MST(N), .RD_LAT(1), .IDW(IDW)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a), .rd_id(rd_id_a),
    .clr_start(clr_start), .clr_busy(clr_busy_a)
  );

  bus_mem_arb #(.DW(DW), .AW(AW), .N_MST(N), .RD_LAT(2), .IDW(IDW)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_id(rd_id_b),
    .clr_start(clr_start), .clr_busy(clr_busy_b)
  );

  // Behavioural model: memory image, which words are defined, fairness turn,
  // clear progress and the reads granted one and two cycles ago.
  logic [DW-1:0] mdl_mem [DEPTH];
  bit            mdl_known [DEPTH];
  int            rr;
  bit            busy;
  int            clr_addr;
  bit            pend_v [N];
  bit            pend_we [N];
  logic [AW-1:0] pend_addr [N];
  logic [DW-1:0] pend_data [N];
  bit            h_v [2];
  int            h_id [2];
  logic [DW-1:0] h_d [2];
  bit            h_k [2];

  int tests = 0;
  int fails = 0;
  int busy_cycles = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_out(input string sfx, input logic v, input logic [DW-1:0] d,
                           input logic [IDW-1:0] id, input int k);
    check({"valid_", sfx}, 32'(v), 32'(h_v[k]));
    if (!h_v[k]) begin
      check({"idle_data_", sfx}, 32'(d), 32'd0);
    end else begin
      check({"id_", sfx}, 32'(id), 32'(h_id[k]));
      if (h_k[k]) check({"data_", sfx}, 32'(d), 32'(h_d[k]));
    end
  endtask

  task automatic set_op(input int m, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    pend_v[m]    = 1'b1;
    pend_we[m]   = w;
    pend_addr[m] = a;
    pend_data[m] = d;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req[i]              = pend_v[i];
      we[i]               = pend_we[i];
      addr[i*AW +: AW]    = pend_addr[i];
      wdata[i*DW +: DW]   = pend_data[i];
    end
  endtask

  task automatic model_reset();
    rr = 0;
    busy = 1'b0;
    clr_addr = 0;
    for (int k = 0; k < 2; k++) begin
      h_v[k] = 1'b0; h_id[k] = 0; h_d[k] = '0; h_k[k] = 1'b0;
    end
    for (int a = 0; a < DEPTH; a++) mdl_known[a] = 1'b0;
  endtask

  // One clock cycle: called #1 after a rising edge, returns #1 after the next.
  task automatic cycle();
    int            g;
    int            im;
    logic [N-1:0]  eg;
    bit            clr_now;
    bit            new_v;
    int            new_id;
    logic [DW-1:0] new_d;
    bit            new_k;
    drive_inputs();
    @(negedge clk);
    g = -1;
    if (!busy) begin
      for (int o = 0; o < N; o++) begin
        im = (rr + o) % N;
        if (g < 0 && pend_v[im]) g = im;
      end
    end
    eg = (g >= 0) ? (N'(1) << g) : '0;
    check("gnt_l1", 32'(gnt_a), 32'(eg));
    check("gnt_l2", 32'(gnt_b), 32'(eg));
    check_out("l1", rd_valid_a, rd_data_a, rd_id_a, 0);
    check_out("l2", rd_valid_b, rd_data_b, rd_id_b, 1);
    check("busy_l1", 32'(clr_busy_a), 32'(busy));
    check("busy_l2", 32'(clr_busy_b), 32'(busy));
    if (clr_busy_a) busy_cycles++;
    clr_now = clr_start;
    @(posedge clk);
    new_v = 1'b0; new_id = 0; new_d = '0; new_k = 1'b0;
    if (g >= 0) begin
      if (pend_we[g]) begin
        mdl_mem[pend_addr[g]]   = pend_data[g];
        mdl_known[pend_addr[g]] = 1'b1;
        $display("[TB] cyc %0d M%0d WR addr 0x%02h data 0x%03h", cyc, g, pend_addr[g], pend_data[g]);
      end else begin
        new_v  = 1'b1;
        new_id = g;
        new_d  = mdl_mem[pend_addr[g]];
        new_k  = mdl_known[pend_addr[g]];
        $display("[TB] cyc %0d M%0d RD addr 0x%02h", cyc, g, pend_addr[g]);
      end
      pend_v[g] = 1'b0;
      rr = (g + 1) % N;
    end
    h_v[1] = h_v[0]; h_id[1] = h_id[0]; h_d[1] = h_d[0]; h_k[1] = h_k[0];
    h_v[0] = new_v;  h_id[0] = new_id;  h_d[0] = new_d;  h_k[0] = new_k;
    if (busy) begin
      mdl_mem[clr_addr]   = '0;
      mdl_known[clr_addr] = 1'b1;
      clr_addr++;
      if (clr_addr == DEPTH) busy = 1'b0;
    end else if (clr_now) begin
      busy = 1'b1;
      clr_addr = 0;
    end
    cyc++;
    #1;
    clr_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Asynchronous reset in mid-cycle: outputs must drop without waiting for an edge.
  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    check("rst_valid_l1", 32'(rd_valid_a), 32'd0);
    check("rst_valid_l2", 32'(rd_valid_b), 32'd0);
    check("rst_data_l1", 32'(rd_data_a), 32'd0);
    check("rst_data_l2", 32'(rd_data_b), 32'd0);
    check("rst_busy_l1", 32'(clr_busy_a), 32'd0);
    check("rst_busy_l2", 32'(clr_busy_b), 32'd0);
    check("rst_gnt_l1", 32'(gnt_a), 32'd0);
    check("rst_gnt_l2", 32'(gnt_b), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_clear(input string tag, input int restart_at);
    int k;
    busy_cycles = 0;
    k = 0;
    while ((busy || k == 0) && k < 400) begin
      if (k == restart_at) clr_start = 1'b1;
      cycle();
      k++;
    end
    check(tag, 32'(busy_cycles), 32'(DEPTH));
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      pend_v[i] = 1'b0; pend_we[i] = 1'b0; pend_addr[i] = '0; pend_data[i] = '0;
    end
    model_reset();

    // Power-on reset state.
    @(posedge clk);
    @(posedge clk);
    #1;
    check("por_valid_l1", 32'(rd_valid_a), 32'd0);
    check("por_valid_l2", 32'(rd_valid_b), 32'd0);
    check("por_data_l1", 32'(rd_data_a), 32'd0);
    check("por_id_l1", 32'(rd_id_a), 32'd0);
    check("por_id_l2", 32'(rd_id_b), 32'd0);
    check("por_busy_l1", 32'(clr_busy_a), 32'd0);
    rst_n = 1'b1;

    // Write then read from the other master.
    set_op(0, 1'b1, 8'h10, 10'h3A5);
    cycle();
    set_op(1, 1'b0, 8'h10, '0);
    cycle();
    idle(3);

    // Fairness: both masters keep requesting reads.
    for (int k = 0; k < 6; k++) begin
      for (int m = 0; m < N; m++) if (!pend_v[m]) set_op(m, 1'b0, 8'h10, '0);
      cycle();
    end
    idle(4);

    // Two-cycle latency path.
    set_op(0, 1'b1, 8'hFF, 10'h2AA);
    cycle();
    set_op(0, 1'b0, 8'hFF, '0);
    cycle();
    idle(4);

    // Clear with requests held throughout.
    set_op(0, 1'b1, 8'h00, 10'h111);
    set_op(1, 1'b1, 8'h80, 10'h222);
    idle(2);
    set_op(0, 1'b1, 8'hFF, 10'h333);
    cycle();
    clr_start = 1'b1;
    cycle();
    set_op(0, 1'b0, 8'h00, '0);
    set_op(1, 1'b0, 8'h80, '0);
    run_clear("clear_len", -1);
    idle(2);
    set_op(0, 1'b0, 8'hFF, '0);
    idle(4);

    // Clear requested together with a write; a second request mid-clear.
    set_op(0, 1'b1, 8'h20, 10'h155);
    clr_start = 1'b1;
    cycle();
    run_clear("clear_len_restart", 100);
    set_op(1, 1'b0, 8'h20, '0);
    idle(4);

    // Random traffic with an occasional clear.
    for (int k = 0; k < 400; k++) begin
      for (int m = 0; m < N; m++) begin
        if (!pend_v[m] && $urandom_range(0, 2) != 0) begin
          set_op(m, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'(8'h10 + $urandom_range(0, 3)),
                 DW'($urandom));
        end
      end
      if ($urandom_range(0, 199) == 0) clr_start = 1'b1;
      cycle();
    end
    for (int k = 0; k < 300 && busy; k++) cycle();
    idle(4);

    // Reset with a read in flight.
    set_op(1, 1'b0, 8'h12, '0);
    cycle();
    mid_reset();
    idle(3);

    // Reset in the middle of a clear with requests pending.
    clr_start = 1'b1;
    cycle();
    set_op(1, 1'b0, 8'h30, '0);
    set_op(0, 1'b0, 8'h31, '0);
    for (int k = 0; k < 300 && clr_addr != 8'h40; k++) cycle();
    check("clr_reached_0x40", 32'(clr_addr), 32'h40);
    mid_reset();
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
